text_buffer: RTL



---
 rtl/text_pkg.sv | 35 +++
 rtl/text_ram.sv | 25 ++
 rtl/text_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants, state encoding and row-rotation helper for the text buffer.
package text_pkg;

  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = ROW_W + COL_W;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_TILDE = 8'h7E;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;

  // Write-side controller states, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t CLR_ALL = 2'd0;
  localparam state_t IDLE    = 2'd1;
  localparam state_t CLR_ROW = 2'd2;

  // Logical row to physical row: (row + top) mod rows, both operands < rows.
  function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] row,
                                                input logic [ROW_W-1:0] top,
                                                input int               rows);
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= (ROW_W+1)'(rows)) sum = sum - (ROW_W+1)'(rows);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHAR_SPACE) && (b <= CHAR_TILDE);
  endfunction

endpackage

// File: rtl/text_ram.sv
// 4096x8 simple dual-port screen RAM: one write port, one registered read port
// with enable. A same-address read and write returns the old contents.
module text_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; the controller
  // clears it by writing spaces after every reset instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character screen memory with a byte-stream terminal write port (cursor,
// CR/LF/BS/FF, scroll by row rotation) and a 1-cycle glyph read port.
// Optional blinking cursor overlay: define TEXT_BUFFER_CURSOR_EN.
module text_buffer
  import text_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 24,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [7:0] rd_char,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  input  logic       frame_start,
  output logic       rd_cursor
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t             state;
  logic [COL_W-1:0]   clr_col;
  logic [ROW_W-1:0]   clr_row;
  logic [ROW_W-1:0]   top;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [7:0]         ram_wdata;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [7:0]         ram_rdata;

  logic               accept;
  logic               printable;
  logic               lf_req;
  logic [ROW_W-1:0]   cur_phys_row;
  logic [ROW_W-1:0]   rd_phys_row;
  logic               rd_oob;
  logic               oob_q;

  // ---------------------------------------------------------------- read path
  assign rd_phys_row = wrap_row(rd_row, top, ROWS);
  assign rd_oob      = (rd_col > LAST_COL) || (rd_row > LAST_ROW);
  assign ram_raddr   = {rd_phys_row, rd_col};

  // rd_char is a mux of two registers that both only load on rd_en, so it
  // holds between strobes; oob_q resetting high yields the space reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      oob_q <= 1'b1;
    else if (rd_en) oob_q <= rd_oob;
  end

  assign rd_char = oob_q ? CHAR_SPACE : ram_rdata;

  text_ram #(.ADDR_W(ADDR_W), .DATA_W(8)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------- write path
  assign wr_ready     = (state == IDLE);
  assign cur_phys_row = wrap_row(cursor_row, top, ROWS);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    accept    = wr_valid && (state == IDLE);
    printable = is_printable(wr_data);
    lf_req    = accept && ((wr_data == CHAR_LF) || (printable && (cursor_col == LAST_COL)));
    ram_we    = 1'b0;
    ram_waddr = {clr_row, clr_col};
    ram_wdata = CHAR_SPACE;
    if (state == CLR_ALL || state == CLR_ROW) begin
      ram_we = 1'b1;
    end else if (accept && printable) begin
      ram_we    = 1'b1;
      ram_waddr = {cur_phys_row, cursor_col};
      ram_wdata = wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLR_ALL;
      clr_col    <= '0;
      clr_row    <= '0;
      top        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            if (clr_row == LAST_ROW) begin
              clr_row <= '0;
              state   <= IDLE;
            end else begin
              clr_row <= clr_row + 1'b1;
            end
          end else begin
            clr_col <= clr_col + 1'b1;
          end
        end

        CLR_ROW: begin
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + 1'b1;
          end
        end

        IDLE: begin
          if (accept) begin
            if (printable) begin
              cursor_col <= (cursor_col == LAST_COL) ? '0 : cursor_col + 1'b1;
            end else begin
              case (wr_data)
                CHAR_CR: cursor_col <= '0;
                CHAR_BS: if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                CHAR_FF: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  top        <= '0;
                  clr_col    <= '0;
                  clr_row    <= '0;
                  state      <= CLR_ALL;
                end
                default: ;
              endcase
            end

            // Scrolling rotates the old top physical row to the bottom and
            // blanks it, so no text is copied.
            if (lf_req) begin
              if (cursor_row != LAST_ROW) begin
                cursor_row <= cursor_row + 1'b1;
              end else begin
                top     <= (top == LAST_ROW) ? '0 : top + 1'b1;
                clr_row <= top;
                clr_col <= '0;
                state   <= CLR_ROW;
              end
            end
          end
        end

        default: state <= CLR_ALL;
      endcase
    end
  end

  // ----------------------------------------------------------- cursor overlay
`ifdef TEXT_BUFFER_CURSOR_EN
  logic        blink_phase;
  logic [15:0] frame_cnt;
  logic        rd_cursor_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_phase <= 1'b1;
      frame_cnt   <= '0;
    end else if (frame_start) begin
      if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_cursor_q <= 1'b0;
    else if (rd_en) rd_cursor_q <= blink_phase && !rd_oob &&
                                   (rd_col == cursor_col) && (rd_row == cursor_row);
  end

  assign rd_cursor = rd_cursor_q;
`else
  logic unused_frame;
  assign unused_frame = frame_start ^ (BLINK_FRAMES < 0);
  assign rd_cursor    = 1'b0;
`endif

endmodule
